// File: rtl/sub40_pkg.sv
// Shared constants and state encoding for the chunked 40-bit subtractor.
// Optional add mode is enabled by defining SUB40_ADD_MODE_EN.
package sub40_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 40;
  localparam int CHUNK_DEF = 8;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter must hold NCHUNK-1; keep at least one bit for a single-chunk build.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sub40_seq_fs_chunk.sv
// Combinational CHUNK-bit ripple full-subtractor: d = a - b - bin.
module fs_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);
  logic [CHUNK:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i]);
  end

  assign bout = br[CHUNK];
endmodule

// File: rtl/sub40_seq.sv
// Multi-cycle WIDTH-bit subtractor, CHUNK bits per clock, valid/ready on both sides.
// Define SUB40_ADD_MODE_EN to add the op port (op=1 selects A + B + Bin).
module sub40_seq
  import sub40_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
`ifdef SUB40_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             Z
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_w(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              brw_q, brw_d, bout_q, bout_d, v_q, v_d, z_q, z_d;

  logic [CHUNK-1:0]  a_ch, b_ch, fs_d;
  logic              fs_bin, fs_bout, brw_nxt, add_mode;
  logic [WIDTH-1:0]  d_new;

`ifdef SUB40_ADD_MODE_EN
  logic op_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 op_q <= 1'b0;
    else if (state_q == ST_IDLE && in_valid)   op_q <= op;
  end
  assign add_mode = op_q;
`else
  assign add_mode = 1'b0;
`endif

  assign a_ch = a_q[int'(cnt_q)*CHUNK +: CHUNK];
  // Addition rides the same subtractor: a + b + c == a - ~b - ~c with carry = ~borrow.
  assign b_ch    = add_mode ? ~b_q[int'(cnt_q)*CHUNK +: CHUNK] : b_q[int'(cnt_q)*CHUNK +: CHUNK];
  assign fs_bin  = add_mode ? ~brw_q : brw_q;
  assign brw_nxt = add_mode ? ~fs_bout : fs_bout;

  fs_chunk #(.CHUNK(CHUNK)) u_fs (
    .a    (a_ch),
    .b    (b_ch),
    .bin  (fs_bin),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;
    d_new   = d_q;
    d_new[int'(cnt_q)*CHUNK +: CHUNK] = fs_d;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        a_d     = A;
        b_d     = B;
        brw_d   = Bin;
        cnt_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        d_d   = d_new;
        brw_d = brw_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bout_d  = brw_nxt;
          v_d     = (add_mode ? (a_q[WIDTH-1] == b_q[WIDTH-1]) : (a_q[WIDTH-1] != b_q[WIDTH-1]))
                    && (d_new[WIDTH-1] != a_q[WIDTH-1]);
          z_d     = (d_new == '0);
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign D         = d_q;
  assign Bout      = bout_q;
  assign V         = v_q;
  assign Z         = z_q;
endmodule

// File: tb/tb_sub40_seq.sv
// Scoreboard bench for sub40_seq: driver pushes expected results, monitor pops on output handshake.
module tb_sub40_seq;
  localparam int W = 40;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         v;
    logic         z;
  } res_t;

  logic         clk = 1'b0, reset = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [W-1:0] A = '0, B = '0, D;
  logic         Bin = 1'b0, Bout, V, Z;

  res_t q[$];
  int   checks = 0, errors = 0;

  sub40_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin),
`ifdef SUB40_ADD_MODE_EN
    .op(1'b0),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .Bout(Bout), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: consume a result whenever the output handshake is presented.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      res_t got, exp;
      got = '{d: D, bout: Bout, v: V, z: Z};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got D=%h B=%b V=%b Z=%b with empty scoreboard",
                 D, Bout, V, Z);
      end else begin
        exp = q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL result: got D=%h B=%b V=%b Z=%b expected D=%h B=%b V=%b Z=%b",
                   got.d, got.bout, got.v, got.z, exp.d, exp.bout, exp.v, exp.z);
        end
      end
    end
  end

  // Waits for in_ready, presents operands, returns #1 after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", in_ready, 1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) to the edge raising out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic ev, input logic ez);
    int lat;
    q.push_back('{d: ed, bout: eb, v: ev, z: ez});
    issue(a, b, bin);
    check("calc_in_ready", in_ready, 0);
    wait_valid(lat);
    check("latency", lat, 6);
    @(posedge clk); #1;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    res_t snap;
    int   lat;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_flags", {Bout, V, Z}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(40'h00_0000_0005, 40'h00_0000_0003, 1'b0, 40'h00_0000_0002, 1'b0, 1'b0, 1'b0);
    run_op(40'h00_0000_0000, 40'h00_0000_0001, 1'b0, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(40'h80_0000_0000, 40'h00_0000_0001, 1'b0, 40'h7F_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op(40'h12_3456_789A, 40'h12_3456_789A, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op(40'h12_3456_789A, 40'h12_3456_789A, 1'b0, 40'h00_0000_0000, 1'b0, 1'b0, 1'b1);
    run_op(40'h00_0000_0100, 40'h00_0000_0001, 1'b0, 40'h00_0000_00FF, 1'b0, 1'b0, 1'b0);

    // Backpressure, operand isolation, and in_valid ignored during CALC.
    out_ready = 1'b0;
    q.push_back('{d: 40'h0F_FFFF_FFFF, bout: 1'b0, v: 1'b0, z: 1'b0});
    issue(40'h10_0000_0000, 40'h00_0000_0001, 1'b0);
    @(posedge clk); #1;
    A = 40'hAA_AAAA_AAAA; B = 40'h55_5555_5555; Bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_out_valid", out_valid, 1);
    snap = '{d: D, bout: Bout, v: V, z: Z};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_stable", {D, Bout, V, Z}, snap);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    repeat (8) @(posedge clk);
    #1 check("pulse_ignored", out_valid, 0);

    // Reset during the second CALC cycle abandons the operation.
    issue(40'h00_1234_5678, 40'h00_0000_0042, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_D", D, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 1'b0;
    run_op(40'h00_0000_0007, 40'h00_0000_0002, 1'b0, 40'h00_0000_0005, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sub40_seq.md
Name: sub40_seq

Overview:
- Multi-cycle 40-bit subtractor, the inverse companion of the team's 40-bit ripple-carry adder: computes D = A - B - Bin, CHUNK bits per clock.
- Operands enter through a valid/ready handshake; the result is held behind a valid/ready handshake.
- Sits in the datapath next to the adder; trades latency for a short borrow chain per cycle.

Parameters:
- WIDTH, 40, operand and result width; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; the calculation takes NCHUNK = WIDTH/CHUNK cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B, Bin are valid this cycle.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- D  output  WIDTH  difference.
- Bout  output  1  final borrow out; 1 iff A < B + Bin, compared unsigned.
- V  output  1  two's-complement signed overflow.
- Z  output  1  D == 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Values during and after reset: state IDLE, in_ready=1, out_valid=0, D=0, Bout=0, V=0, Z=0; internal registers cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch A, B, Bin into internal registers, set the chunk counter to 0 and the running borrow to Bin, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, subtract chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of B, plus the running borrow, from chunk k of A.
  - Write the result into D[chunk k] and update the running borrow.
  - After chunk NCHUNK-1: Bout = final borrow; V = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]); Z = (D == 0). Go to DONE.
- DONE:
  - out_valid=1; D/Bout/V/Z stay stable while out_valid=1 and out_ready=0.
  - On out_ready: out_valid falls next cycle and the state returns to IDLE.
- Latency: out_valid rises exactly NCHUNK+1 clock edges after the accept edge (6 for the defaults).
- Throughput: one operation per NCHUNK+2 cycles, with no overlap; in_ready is high only in IDLE.
- Operand isolation: A/B/Bin may change after acceptance without effect.
- out_ready in IDLE/CALC: ignored.
- in_valid outside IDLE: ignored; operands are not queued.
- D, Bout, V, Z hold their last values in IDLE until the next result is written.
- Reset asserted mid-CALC or mid-DONE: the operation is abandoned and all outputs take their reset values immediately; in_ready is 1 once reset releases.
- Wrap-around: D is the WIDTH-bit modulo result; no saturation.
- Chunk counter width: clog2(NCHUNK); it must not wrap before DONE.

Optional Feature:
- Macro: SUB40_ADD_MODE_EN.
- Defined:
  - Extra input port op (1 bit) is latched with the operands; op=1 selects addition (D = A + B + Bin).
  - In add mode, Bout reports carry out and V = (A[MSB]==B[MSB]) && (D[MSB]!=A[MSB]).
  - op=0 behaves exactly as subtraction.
- Undefined: the op port does not exist; subtract only; timing is identical.

Decomposition:
- Package sub40_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Default WIDTH/CHUNK constants.
  - NCHUNK and counter-width calculations.
- Sub-module fs_chunk: combinational CHUNK-bit ripple full-subtractor chain.
  - Inputs: a, b, bin. Outputs: d, bout.
  - In add mode, fs_chunk is fed inverted b and inverted borrow.
  - Instantiated once in sub40_seq and reused every CALC cycle.

Test Plan:
- Basic subtraction: A=0x00_0000_0005, B=0x00_0000_0003, Bin=0 -> D=0x00_0000_0002, Bout=0, V=0, Z=0; out_valid exactly 6 cycles after the accept edge.
- Unsigned underflow: A=0, B=1, Bin=0 -> D=0xFF_FFFF_FFFF, Bout=1, V=0, Z=0.
- Signed overflow: A=0x80_0000_0000, B=0x00_0000_0001 -> D=0x7F_FFFF_FFFF, Bout=0, V=1.
- Borrow-in ripple across every chunk:
  - A=B=0x12_3456_789A, Bin=1 -> D=0xFF_FFFF_FFFF, Bout=1.
  - Same operands with Bin=0 -> D=0, Z=1, Bout=0.
- Backpressure and isolation:
  - Hold out_ready=0 for 4 cycles in DONE -> D/flags stable, in_ready=0.
  - Change A and B mid-CALC -> result unaffected.
  - Pulse in_valid during CALC -> ignored.
  - Raise out_ready -> back to IDLE and in_ready=1 on the next cycle.
- Reset mid-operation: assert reset during the 2nd CALC cycle -> out_valid=0, D=0, in_ready=1 immediately; a fresh op (A=7, B=2) then gives D=5.
